fifo_rx_stream_adapter: RTL and testbench

Consumer-side companion to the 8-entry async FIFO. It sits in the clk_rx domain and drives the FIFO's pop_rx/empty_rx/DO_rx read port. It converts that port into a registered valid/ready stream with a 2-entry skid buffer, so a downstream crossbar output port gets full throughput with no combinational path from out_ready to pop_rx. It also provides a flush/drain sequence and delivered/discarded word counters.

---
 rtl/fifo_rx_stream_adapter_if.sv | 21 ++
 rtl/fifo_rx_stream_adapter.sv | 116 +++++++++++
 tb/tb_fifo_rx_stream_adapter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rx_stream_adapter_if.sv
// rtl/fifo_rx_stream_adapter_if.sv - FIFO read port and output stream grouped for the rx adapter
interface fifo_rx_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  empty_rx;
    logic [DATA_WIDTH-1:0] DO_rx;
    logic                  pop_rx;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        input  empty_rx, DO_rx, out_ready,
        output pop_rx, out_valid, out_data
    );

    modport slave (
        output empty_rx, DO_rx, out_ready,
        input  pop_rx, out_valid, out_data
    );
endinterface

// File: rtl/fifo_rx_stream_adapter.sv
// rtl/fifo_rx_stream_adapter.sv - async FIFO read port to registered valid/ready stream with flush
module fifo_rx_stream_adapter #(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int FLUSH_QUIET = 4
) (
    input  logic                          clk_rx,
    input  logic                          nrst_rx,
    fifo_rx_stream_adapter_if.master      bus,
    input  logic                          flush_req,
    output logic                          flush_busy,
    output logic [CNT_WIDTH-1:0]          deliv_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);
    localparam int QW = $clog2(FLUSH_QUIET + 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [QW-1:0]         quiet_q, quiet_d;
    logic [CNT_WIDTH-1:0]  deliv_q, deliv_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;
    logic                  pop, hs, wr_en;
    logic [CNT_WIDTH+1:0]  drop_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        tail_d   = tail_q;
        quiet_d  = quiet_q;
        deliv_d  = deliv_q;
        drop_d   = drop_q;
        pop      = 1'b0;
        hs       = 1'b0;
        wr_en    = 1'b0;
        drop_sum = '0;
        case (state_q)
            ST_RUN: begin
                // Pop depends only on occupancy and empty_rx, keeping out_ready off the FIFO path.
                pop = ~bus.empty_rx & (cnt_q != 2'd2);
                hs  = (cnt_q != 2'd0) & bus.out_ready;
                if (flush_req) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = 2'd0;
                    head_d   = 1'b0;
                    tail_d   = 1'b0;
                    quiet_d  = '0;
                    drop_sum = {2'b00, drop_q} + {{CNT_WIDTH{1'b0}}, cnt_q}
                             + {{(CNT_WIDTH+1){1'b0}}, pop};
                    if (drop_sum > {2'b00, {CNT_WIDTH{1'b1}}})
                        drop_d = '1;
                    else
                        drop_d = drop_sum[CNT_WIDTH-1:0];
                end else begin
                    wr_en = pop;
                    if (pop) tail_d = ~tail_q;
                    if (hs) begin
                        head_d  = ~head_q;
                        deliv_d = deliv_q + 1'b1;
                    end
                    cnt_d = cnt_q + {1'b0, pop} - {1'b0, hs};
                end
            end
            ST_FLUSH: begin
                pop = ~bus.empty_rx;
                if (pop && (drop_q != {CNT_WIDTH{1'b1}}))
                    drop_d = drop_q + 1'b1;
                if (flush_req || !bus.empty_rx)
                    quiet_d = '0;
                else
                    quiet_d = quiet_q + 1'b1;
                if (quiet_d == QW'(FLUSH_QUIET)) begin
                    state_d = ST_RUN;
                    quiet_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_rx or negedge nrst_rx) begin
        if (!nrst_rx) begin
            state_q  <= ST_RUN;
            cnt_q    <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            quiet_q  <= '0;
            deliv_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            quiet_q <= quiet_d;
            deliv_q <= deliv_d;
            drop_q  <= drop_d;
            if (wr_en) mem_q[tail_q] <= bus.DO_rx;
        end
    end

    // Gating with nrst_rx keeps the pop strobe low for the whole reset window.
    assign bus.pop_rx    = nrst_rx & pop;
    assign bus.out_valid = (state_q == ST_RUN) & (cnt_q != 2'd0);
    assign bus.out_data  = mem_q[head_q];
    assign flush_busy    = (state_q == ST_FLUSH);
    assign deliv_cnt     = deliv_q;
    assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_fifo_rx_stream_adapter.sv
// tb/tb_fifo_rx_stream_adapter.sv - directed bench for fifo_rx_stream_adapter with a behavioural FIFO
module tb_fifo_rx_stream_adapter;
    logic       clk_rx;
    logic       nrst_rx;
    logic       flush_req;
    logic       flush_busy;
    logic [3:0] deliv_cnt;
    logic [3:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fq [$];

    fifo_rx_stream_adapter_if #(.DATA_WIDTH(32)) bus ();

    fifo_rx_stream_adapter #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (4),
        .FLUSH_QUIET(4)
    ) dut (
        .clk_rx    (clk_rx),
        .nrst_rx   (nrst_rx),
        .bus       (bus),
        .flush_req (flush_req),
        .flush_busy(flush_busy),
        .deliv_cnt (deliv_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk_rx = 1'b0;
        forever #5 clk_rx = ~clk_rx;
    end

    function automatic void fifo_refresh();
        bus.empty_rx = (fq.size() == 0);
        bus.DO_rx    = (fq.size() == 0) ? 32'h0 : fq[0];
    endfunction

    initial begin
        logic p;
        forever begin
            @(posedge clk_rx);
            p = bus.pop_rx;
            #1;
            if (p && fq.size() > 0) void'(fq.pop_front());
            fifo_refresh();
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        nrst_rx = 1'b0;
        flush_req = 1'b0;
        bus.out_ready = 1'b0;
        fq.delete();
        fifo_refresh();
        repeat (2) @(negedge clk_rx);
        n_checks++; if (bus.pop_rx !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b want 0", bus.pop_rx); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        n_checks++; if (deliv_cnt !== 4'h0 || drop_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", deliv_cnt, drop_cnt); end
        n_checks++; if (flush_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", flush_busy); end
        nrst_rx = 1'b1;
        @(negedge clk_rx);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.pop_rx !== 1'b0) begin n_fail++; $display("FAIL idle_empty: valid %b pop %b want 0 0", bus.out_valid, bus.pop_rx); end
    endtask

    task automatic test_full_rate();
        int k;
        logic [31:0] exp [8];
        for (int i = 0; i < 8; i++) begin exp[i] = 32'h11 * (i + 1); fq.push_back(exp[i]); end
        fifo_refresh();
        bus.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 8; c++) begin
            @(negedge clk_rx); #1;
            if (bus.out_valid) begin
                n_checks++;
                if (bus.out_data !== exp[k]) begin n_fail++; $display("FAIL full_rate_data[%0d]: got %h want %h", k, bus.out_data, exp[k]); end
                k++;
            end else if (k > 0) begin
                n_checks++; n_fail++;
                $display("FAIL full_rate_bubble: valid 0 after %0d words, want 1", k);
            end
        end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL full_rate_count: got %0d words want 8", k); end
        @(negedge clk_rx);
        n_checks++; if (deliv_cnt !== 4'd8) begin n_fail++; $display("FAIL full_rate_deliv: got %0d want 8", deliv_cnt); end
    endtask

    task automatic test_stall();
        int k;
        logic [31:0] exp [8];
        for (int i = 0; i < 8; i++) begin exp[i] = 32'h11 * (i + 1); fq.push_back(exp[i]); end
        fifo_refresh();
        bus.out_ready = 1'b0;
        @(negedge clk_rx);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk_rx); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11 || bus.pop_rx !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid %b data %h pop %b want 1 00000011 0", s, bus.out_valid, bus.out_data, bus.pop_rx);
            end
        end
        bus.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 8; c++) begin
            if (c > 0) @(negedge clk_rx);
            #1;
            if (bus.out_valid) begin
                n_checks++;
                if (bus.out_data !== exp[k]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", k, bus.out_data, exp[k]); end
                k++;
            end
        end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL stall_count: got %0d words want 8", k); end
        @(negedge clk_rx);
        n_checks++; if (deliv_cnt !== 4'd0) begin n_fail++; $display("FAIL stall_deliv: got %0d want 0 (16 mod 16)", deliv_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] sb [$];
        int pushed, got, errs, stab_errs;
        logic prev_stall;
        logic [31:0] prev_data, w;
        pushed = 0; got = 0; errs = 0; stab_errs = 0;
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 5000 && got < 200; c++) begin
            @(negedge clk_rx);
            bus.out_ready = $urandom_range(0, 1);
            if (pushed < 200 && fq.size() < 8 && $urandom_range(0, 1) == 1) begin
                w = 32'hA000_0000 + pushed * 32'h0001_0003;
                fq.push_back(w);
                sb.push_back(w);
                pushed++;
                fifo_refresh();
            end
            #1;
            if (prev_stall && bus.out_data !== prev_data) begin
                stab_errs++;
                if (stab_errs < 4) $display("FAIL random_stable: got %h want %h", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0 || bus.out_data !== sb[0]) begin
                    errs++;
                    if (errs < 4) $display("FAIL random_order[%0d]: got %h want %h", got, bus.out_data, (sb.size() > 0) ? sb[0] : 32'hx);
                end
                if (sb.size() > 0) void'(sb.pop_front());
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
        bus.out_ready = 1'b1;
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL random_order_total: got %0d errors want 0", errs); end
        n_checks++; if (stab_errs != 0) begin n_fail++; $display("FAIL random_stable_total: got %0d errors want 0", stab_errs); end
        n_checks++; if (got != 200) begin n_fail++; $display("FAIL random_count: got %0d want 200", got); end
        @(negedge clk_rx);
        n_checks++; if (deliv_cnt !== 4'd8) begin n_fail++; $display("FAIL random_deliv: got %0d want 8 (216 mod 16)", deliv_cnt); end
        n_checks++; if (drop_cnt !== 4'd0) begin n_fail++; $display("FAIL random_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_flush();
        int busy_cycles;
        logic seen;
        for (int i = 0; i < 6; i++) fq.push_back(32'hF0 + i);
        fifo_refresh();
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk_rx);
        flush_req = 1'b1;
        @(negedge clk_rx);
        flush_req = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || flush_busy !== 1'b1) begin n_fail++; $display("FAIL flush_enter: valid %b busy %b want 0 1", bus.out_valid, flush_busy); end
        busy_cycles = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_rx); #1;
            if (!flush_busy) break;
            busy_cycles++;
        end
        n_checks++; if (busy_cycles != 8) begin n_fail++; $display("FAIL flush_busy_len: got %0d want 8", busy_cycles); end
        n_checks++; if (drop_cnt !== 4'd6) begin n_fail++; $display("FAIL flush_drop: got %0d want 6", drop_cnt); end
        n_checks++; if (fq.size() != 0) begin n_fail++; $display("FAIL flush_drained: got %0d words left want 0", fq.size()); end
        fq.push_back(32'hAB);
        fifo_refresh();
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk_rx); #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                n_checks++; if (bus.out_data !== 32'hAB) begin n_fail++; $display("FAIL flush_after_data: got %h want ab", bus.out_data); end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL flush_after_valid: got 0 want 1"); end
        @(negedge clk_rx);
        n_checks++; if (deliv_cnt !== 4'd9) begin n_fail++; $display("FAIL flush_after_deliv: got %0d want 9", deliv_cnt); end
    endtask

    task automatic test_saturate_wrap_reset();
        int got;
        logic [3:0] exp_drop [2];
        exp_drop[0] = 4'd14;
        exp_drop[1] = 4'd15;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) fq.push_back(32'hD0 + i);
            fifo_refresh();
            bus.out_ready = 1'b0;
            repeat (3) @(negedge clk_rx);
            flush_req = 1'b1;
            @(negedge clk_rx);
            flush_req = 1'b0;
            for (int c = 0; c < 40 && flush_busy; c++) @(negedge clk_rx);
            n_checks++; if (flush_busy !== 1'b0) begin n_fail++; $display("FAIL sat_flush_done[%0d]: busy %b want 0", r, flush_busy); end
            n_checks++; if (drop_cnt !== exp_drop[r]) begin n_fail++; $display("FAIL sat_drop[%0d]: got %0d want %0d", r, drop_cnt, exp_drop[r]); end
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < ((b == 0) ? 6 : 1); i++) fq.push_back(32'hC0 + i);
            fifo_refresh();
            bus.out_ready = 1'b1;
            got = 0;
            for (int c = 0; c < 20 && got < ((b == 0) ? 6 : 1); c++) begin
                @(negedge clk_rx); #1;
                if (bus.out_valid) got++;
            end
            @(negedge clk_rx);
            n_checks++;
            if (deliv_cnt !== ((b == 0) ? 4'd15 : 4'd0)) begin
                n_fail++;
                $display("FAIL wrap_deliv[%0d]: got %0d want %0d", b, deliv_cnt, (b == 0) ? 15 : 0);
            end
        end
        for (int i = 0; i < 8; i++) fq.push_back(32'hE0 + i);
        fifo_refresh();
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk_rx);
        #2 nrst_rx = 1'b0;
        #1;
        n_checks++; if (bus.pop_rx !== 1'b0) begin n_fail++; $display("FAIL async_reset_pop: got %b want 0", bus.pop_rx); end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin n_fail++; $display("FAIL async_reset_out: valid %b data %h want 0 0", bus.out_valid, bus.out_data); end
        n_checks++; if (deliv_cnt !== 4'd0 || drop_cnt !== 4'd0 || flush_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_cnt: deliv %0d drop %0d busy %b want 0 0 0", deliv_cnt, drop_cnt, flush_busy); end
        fq.delete();
        fifo_refresh();
        @(negedge clk_rx);
        nrst_rx = 1'b1;
        @(negedge clk_rx);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_random();
        test_flush();
        test_saturate_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
